apb_initiator_bridge: RTL and testbench

Single-outstanding bridge that turns the SoC's lint-style request/grant port into APB transfers, acting as the initiator on the peripheral bus. It sits upstream of the peripheral APB interconnect and drives that interconnect's APB slave port. One transfer is in flight at a time. A programmable wait-state timeout keeps a hung peripheral from stalling the core.

---
 rtl/apb_initiator_pkg.sv | 14 +
 rtl/apb_initiator_wdog.sv | 38 +++
 rtl/apb_initiator_bridge.sv | 112 +++++++++++
 tb/tb_apb_initiator_bridge.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_initiator_pkg.sv
// Shared types for the APB initiator bridge: FSM state encoding and the data
// value returned on a timed-out transfer.
package apb_initiator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_e;

  // Replicated across the data width when a transfer times out.
  localparam bit ERR_RDATA = 1'b0;

endpackage

// File: rtl/apb_initiator_wdog.sv
// Saturating ACCESS-phase wait counter; expired_o is combinational from the count.
// No backpressure; clear has priority over enable.
module apb_initiator_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic w_unused;
      assign w_unused  = clk_i ^ rst_i ^ clear_i ^ enable_i;
      assign expired_o = 1'b0;
    end else begin : g_on
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_cnt <= '0;
        end else if (clear_i) begin
          r_cnt <= '0;
        end else if (enable_i && (r_cnt != LIMIT)) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      assign expired_o = (r_cnt == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/apb_initiator_bridge.sv
// Lint request/grant to APB initiator, one transfer in flight; 3-cycle zero-wait latency.
// Requests are held off (gnt_o low) until the bridge returns to IDLE.
module apb_initiator_bridge
  import apb_initiator_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0]   add_i,
  input  logic                        wen_i,
  input  logic [APB_DATA_WIDTH/8-1:0] be_i,
  input  logic [APB_DATA_WIDTH-1:0]   wdata_i,
  output logic                        r_valid_o,
  output logic [APB_DATA_WIDTH-1:0]   r_rdata_o,
  output logic                        r_opc_o,
  output logic [APB_ADDR_WIDTH-1:0]   paddr_o,
  output logic [APB_DATA_WIDTH-1:0]   pwdata_o,
  output logic                        pwrite_o,
  output logic [APB_DATA_WIDTH/8-1:0] pstrb_o,
  output logic                        psel_o,
  output logic                        penable_o,
  input  logic                        pready_i,
  input  logic [APB_DATA_WIDTH-1:0]   prdata_i,
  input  logic                        pslverr_i
);

  localparam int unsigned BE_W = APB_DATA_WIDTH / 8;

  state_e                    r_state;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [APB_DATA_WIDTH-1:0] r_pwdata;
  logic                      r_pwrite;
  logic [BE_W-1:0]           r_pstrb;
  logic                      r_rsp_vld;
  logic [APB_DATA_WIDTH-1:0] r_rsp_rdata;
  logic                      r_rsp_opc;

  logic w_expired;
  logic w_done;
  logic w_timeout;

  assign gnt_o     = req_i && (r_state == IDLE);
  assign psel_o    = (r_state != IDLE);
  assign penable_o = (r_state == ACCESS);

  // A real response in the expiring cycle takes precedence over the timeout.
  assign w_done    = (r_state == ACCESS) && pready_i;
  assign w_timeout = (r_state == ACCESS) && !pready_i && w_expired;

  apb_initiator_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (r_state == SETUP),
    .enable_i ((r_state == ACCESS) && !pready_i),
    .expired_o(w_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pwrite    <= 1'b0;
      r_pstrb     <= '0;
      r_rsp_vld   <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_opc   <= 1'b0;
    end else begin
      r_rsp_vld <= w_done || w_timeout;
      case (r_state)
        IDLE: begin
          if (gnt_o) begin
            r_paddr  <= add_i;
            r_pwdata <= wdata_i;
            r_pwrite <= !wen_i;
            r_pstrb  <= wen_i ? '0 : be_i;
            r_state  <= SETUP;
          end
        end
        SETUP: r_state <= ACCESS;
        ACCESS: begin
          if (w_done) begin
            r_rsp_rdata <= r_pwrite ? '0 : prdata_i;
            r_rsp_opc   <= pslverr_i;
            r_state     <= IDLE;
          end else if (w_timeout) begin
            r_rsp_rdata <= {APB_DATA_WIDTH{ERR_RDATA}};
            r_rsp_opc   <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign paddr_o   = r_paddr;
  assign pwdata_o  = r_pwdata;
  assign pwrite_o  = r_pwrite;
  assign pstrb_o   = r_pstrb;
  assign r_valid_o = r_rsp_vld;
  assign r_rdata_o = r_rsp_rdata;
  assign r_opc_o   = r_rsp_opc;

endmodule

// File: tb/tb_apb_initiator_bridge.sv
// Directed bench for apb_initiator_bridge with a cycle-count transaction model
// checked every cycle, plus literal expectations from the documented timing.
module tb_apb_initiator_bridge;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic [31:0] add_i = '0;
  logic        wen_i = 1'b1;
  logic [3:0]  be_i = '0;
  logic [31:0] wdata_i = '0;
  logic        pready_i = 1'b0;
  logic [31:0] prdata_i = '0;
  logic        pslverr_i = 1'b0;

  logic        gnt_o, r_valid_o, r_opc_o, pwrite_o, psel_o, penable_o;
  logic [31:0] r_rdata_o, paddr_o, pwdata_o;
  logic [3:0]  pstrb_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  apb_initiator_bridge #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
    .add_i(add_i), .wen_i(wen_i), .be_i(be_i), .wdata_i(wdata_i),
    .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o), .pstrb_o(pstrb_o),
    .psel_o(psel_o), .penable_o(penable_o),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  // Model: m_age counts cycles since the grant (1 = SETUP, >=2 = ACCESS).
  bit          m_init = 0;
  bit          m_busy = 0;
  int          m_age = 0;
  logic [31:0] m_paddr, m_pwdata, m_rdata;
  logic        m_pwrite, m_opc, m_rvld;
  logic [3:0]  m_pstrb;

  always @(negedge clk_i) begin
    if (m_init) begin
      chk("gnt",     gnt_o,     req_i && !m_busy);
      chk("psel",    psel_o,    m_busy);
      chk("penable", penable_o, m_busy && (m_age >= 2));
      chk("paddr",   paddr_o,   m_paddr);
      chk("pwdata",  pwdata_o,  m_pwdata);
      chk("pwrite",  pwrite_o,  m_pwrite);
      chk("pstrb",   pstrb_o,   m_pstrb);
      chk("r_valid", r_valid_o, m_rvld);
      chk("r_rdata", r_rdata_o, m_rdata);
      chk("r_opc",   r_opc_o,   m_opc);
    end
    if (rst_i) begin
      m_init = 1; m_busy = 0; m_age = 0;
      m_paddr = '0; m_pwdata = '0; m_pwrite = 0; m_pstrb = '0;
      m_rvld = 0; m_rdata = '0; m_opc = 0;
    end else if (m_init) begin
      m_rvld = 0;
      if (!m_busy) begin
        if (req_i) begin
          m_busy = 1; m_age = 1;
          m_paddr = add_i; m_pwdata = wdata_i; m_pwrite = !wen_i;
          m_pstrb = wen_i ? 4'h0 : be_i;
        end
      end else if (m_age < 2) begin
        m_age++;
      end else if (pready_i) begin
        m_rvld = 1; m_opc = pslverr_i; m_rdata = m_pwrite ? 32'h0 : prdata_i; m_busy = 0;
      end else if (TO != 0 && (m_age - 2) == TO) begin
        m_rvld = 1; m_opc = 1; m_rdata = 32'h0; m_busy = 0;
      end else begin
        m_age++;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a request and holds it until granted; returns in the SETUP cycle.
  task automatic req_wait(input logic [31:0] a, input logic rd, input logic [3:0] be,
                          input logic [31:0] wd, output int gcyc);
    req_i = 1; add_i = a; wen_i = rd; be_i = be; wdata_i = wd;
    gcyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (gnt_o) begin
        gcyc = cyc;
        tick();
        break;
      end
      tick();
    end
    req_i = 0;
    if (gcyc < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL grant_wait: no grant within 20 cycles for addr %h", a);
    end
  endtask

  initial begin
    #100000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int g;
    int idx;
    int gc[4];
    logic [31:0] addrs[4];

    repeat (3) tick();
    @(negedge clk_i);
    chk("rst_psel", psel_o, 0);
    chk("rst_paddr", paddr_o, 32'h0);
    chk("rst_rvalid", r_valid_o, 0);
    rst_i = 0;
    tick();

    // Zero-wait read
    req_wait(32'h1A10_0000, 1'b1, 4'hF, 32'h0, g);
    pready_i = 1; prdata_i = 32'hCAFE_F00D;
    @(negedge clk_i);
    chk("rd_setup_psel", psel_o, 1);
    chk("rd_setup_penable", penable_o, 0);
    chk("rd_pstrb_zero", pstrb_o, 4'h0);
    tick();
    @(negedge clk_i);
    chk("rd_access_penable", penable_o, 1);
    tick();
    pready_i = 0;
    @(negedge clk_i);
    chk("rd_rvalid", r_valid_o, 1);
    chk("rd_latency", cyc - g, 3);
    chk("rd_rdata", r_rdata_o, 32'hCAFE_F00D);
    chk("rd_opc", r_opc_o, 0);
    chk("rd_done_psel", psel_o, 0);

    // Write with 3 wait states; error/data lines toggle while not ready
    req_wait(32'h1A10_4008, 1'b0, 4'b0011, 32'h1234_5678, g);
    pready_i = 0; pslverr_i = 1; prdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    chk("wr_pwrite", pwrite_o, 1);
    chk("wr_pstrb", pstrb_o, 4'b0011);
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin pready_i = 1; pslverr_i = 0; end
      @(negedge clk_i);
      chk("wr_paddr_stable", paddr_o, 32'h1A10_4008);
      chk("wr_pwdata_stable", pwdata_o, 32'h1234_5678);
      tick();
    end
    pready_i = 0;
    @(negedge clk_i);
    chk("wr_rvalid", r_valid_o, 1);
    chk("wr_latency", cyc - g, 6);
    chk("wr_opc", r_opc_o, 0);
    chk("wr_rdata", r_rdata_o, 32'h0);

    // Read completing with PSLVERR
    req_wait(32'h1A10_0010, 1'b1, 4'hF, 32'h0, g);
    pready_i = 1; pslverr_i = 1; prdata_i = 32'hFFFF_FFFF;
    tick();
    tick();
    pready_i = 0; pslverr_i = 0;
    @(negedge clk_i);
    chk("err_rvalid", r_valid_o, 1);
    chk("err_opc", r_opc_o, 1);
    chk("err_rdata", r_rdata_o, 32'hFFFF_FFFF);

    // Timeout: pready stuck low for TO+1 ACCESS cycles
    req_wait(32'h1A10_0020, 1'b1, 4'hF, 32'h0, g);
    pready_i = 0; prdata_i = 32'hDEAD_BEEF;
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      chk("to_penable", penable_o, 1);
      tick();
    end
    @(negedge clk_i);
    chk("to_psel_drop", psel_o, 0);
    chk("to_rvalid", r_valid_o, 1);
    chk("to_latency", cyc - g, 7);
    chk("to_opc", r_opc_o, 1);
    chk("to_rdata", r_rdata_o, 32'h0);

    // pready arrives on the cycle the timeout would fire
    req_wait(32'h1A10_0024, 1'b1, 4'hF, 32'h0, g);
    tick();
    repeat (4) tick();
    pready_i = 1; prdata_i = 32'h55AA_1234;
    tick();
    pready_i = 0;
    @(negedge clk_i);
    chk("late_rvalid", r_valid_o, 1);
    chk("late_opc", r_opc_o, 0);
    chk("late_rdata", r_rdata_o, 32'h55AA_1234);

    // Back-to-back: req held high across four requests
    addrs[0] = 32'h1A10_1000; addrs[1] = 32'h1A10_1004;
    addrs[2] = 32'h1A10_1008; addrs[3] = 32'h1A10_100C;
    idx = 0;
    pready_i = 1; prdata_i = 32'h0000_0A0A;
    for (int k = 0; k < 30 && idx < 4; k++) begin
      req_i = 1; add_i = addrs[idx]; wen_i = 1; be_i = 4'hF;
      @(negedge clk_i);
      if (gnt_o) begin
        gc[idx] = cyc;
        idx++;
      end
      tick();
    end
    req_i = 0;
    repeat (3) tick();
    pready_i = 0;
    chk("burst_count", idx, 4);
    for (int i = 1; i < 4; i++) chk("burst_gap", gc[i] - gc[i-1], 3);

    // Reset during ACCESS
    req_wait(32'h1A10_0030, 1'b0, 4'hF, 32'hA5A5_A5A5, g);
    pready_i = 0;
    tick();
    tick();
    rst_i = 1;
    tick();
    rst_i = 0;
    @(negedge clk_i);
    chk("rmid_psel", psel_o, 0);
    chk("rmid_penable", penable_o, 0);
    chk("rmid_paddr", paddr_o, 32'h0);
    chk("rmid_pwdata", pwdata_o, 32'h0);
    chk("rmid_pwrite", pwrite_o, 0);
    chk("rmid_pstrb", pstrb_o, 4'h0);
    chk("rmid_rdata", r_rdata_o, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("rmid_no_rvalid", r_valid_o, 0);
      tick();
    end
    req_wait(32'h1A10_0040, 1'b0, 4'b1100, 32'h0BAD_F00D, g);
    pready_i = 1;
    tick();
    tick();
    pready_i = 0;
    @(negedge clk_i);
    chk("post_rst_rvalid", r_valid_o, 1);
    chk("post_rst_opc", r_opc_o, 0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
